cordic_vectoring: RTL and testbench

//  Inverse of the rotation-mode sin/cos generator: iterative vectoring-mode CORDIC.

---
 rtl/cordic_pkg.sv | 42 ++++
 rtl/cordic_vectoring_if.sv | 32 +++
 rtl/cordic_vec_iter.sv | 45 ++++
 rtl/cordic_vectoring.sv | 187 ++++++++++++++++++
 tb/tb_cordic_vectoring.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants for the vectoring CORDIC: atan LUT, gain
//                compensation shift-add terms, pi constants (all Q3.11) and
//                the controller state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

  localparam int c_lut_width = 14;
  localparam int c_lut_depth = 12;

  typedef logic signed [c_lut_width-1:0] lut_t;

  // atan(2^-i) in Q3.11, i = 0..11
  localparam lut_t c_atan_lut [c_lut_depth] = '{
    14'sd1608, 14'sd950, 14'sd502, 14'sd255, 14'sd128, 14'sd64,
    14'sd32,   14'sd16,  14'sd8,   14'sd4,   14'sd2,   14'sd1
  };

  localparam lut_t c_pi   = 14'sd6434;
  localparam lut_t c_pi_2 = 14'sd3217;

  // K = 0.60725 ~ 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 (= 0.60718)
  localparam int c_k_terms = 5;
  localparam int c_k_shift [c_k_terms] = '{1, 3, 6, 9, 12};
  localparam bit c_k_sub   [c_k_terms] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREROT = 3'd1,
    S_ITER   = 3'd2,
    S_SCALE  = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cordic_vectoring_if.sv
// ============================================================================
//  Module      : cordic_vectoring_if
//  Description : Valid/ready input and output channels of the vectoring
//                CORDIC. slave = the CORDIC block, master = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_vectoring_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic                         out_valid;
  logic                         out_ready;
  logic        [DATA_WIDTH-1:0] mag_out;
  logic signed [DATA_WIDTH-1:0] angle_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out
  );
endinterface

`default_nettype wire

// File: rtl/cordic_vec_iter.sv
// ============================================================================
//  Module      : cordic_vec_iter
//  Description : One combinational vectoring micro-rotation. Drives y toward
//                zero, accumulating the rotated angle in z.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_vec_iter #(
  parameter int WIDTH     = 14,
  parameter int IDX_WIDTH = 4
) (
  input  logic signed [WIDTH-1:0]     x,
  input  logic signed [WIDTH-1:0]     y,
  input  logic signed [WIDTH-1:0]     z,
  input  logic        [IDX_WIDTH-1:0] i,
  input  logic signed [WIDTH-1:0]     atan,
  output logic signed [WIDTH-1:0]     x_next,
  output logic signed [WIDTH-1:0]     y_next,
  output logic signed [WIDTH-1:0]     z_next
);

  logic signed [WIDTH-1:0] w_x_sh;
  logic signed [WIDTH-1:0] w_y_sh;

  // both shifts use the pre-update operands
  assign w_x_sh = x >>> i;
  assign w_y_sh = y >>> i;

  // rotate clockwise when y is non-negative, counter-clockwise otherwise
  always_comb begin
    if (y[WIDTH-1]) begin
      x_next = x - w_y_sh;
      y_next = y + w_x_sh;
      z_next = z - atan;
    end else begin
      x_next = x + w_y_sh;
      y_next = y - w_x_sh;
      z_next = z + atan;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_vectoring.sv
// ============================================================================
//  Module      : cordic_vectoring
//  Description : Iterative vectoring-mode CORDIC: (x,y) -> magnitude and
//                atan2(y,x). One micro-rotation per cycle, valid/ready on
//                both sides, no input buffering.
//                Optional macro GAIN_COMP_EN: adds a SCALE step multiplying
//                the magnitude by K so mag_out is the true magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INT_WIDTH  = 14,
  parameter int ITER_COUNT = 12
) (
  input  logic               clk,
  input  logic               rst,
  cordic_vectoring_if.slave  bus
);

  localparam int IDX_WIDTH = 4;
  localparam int IN_SHIFT  = (INT_WIDTH - 3) - (DATA_WIDTH - 1);
  localparam int MAG_SHIFT = (INT_WIDTH - 3) - (DATA_WIDTH - 1);
  localparam int ANG_SHIFT = (INT_WIDTH - 3) - (DATA_WIDTH - 3);

  localparam logic [IDX_WIDTH-1:0] c_last_iter = IDX_WIDTH'(ITER_COUNT - 1);
  localparam logic signed [INT_WIDTH:0] c_mag_half = (INT_WIDTH+1)'(1 << (MAG_SHIFT - 1));
  localparam logic signed [INT_WIDTH:0] c_ang_half = (INT_WIDTH+1)'(1 << (ANG_SHIFT - 1));
  localparam logic signed [INT_WIDTH:0] c_mag_max  = (INT_WIDTH+1)'((1 << DATA_WIDTH) - 1);
  localparam logic signed [INT_WIDTH:0] c_ang_max  = (INT_WIDTH+1)'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [INT_WIDTH:0] c_ang_min  = (INT_WIDTH+1)'(-(1 << (DATA_WIDTH - 1)));

  state_t                         r_state;
  logic signed [INT_WIDTH-1:0]    r_x, r_y, r_z;
  logic        [IDX_WIDTH-1:0]    r_iter;
  logic                           r_zero;
  logic                           r_in_ready;
  logic                           r_out_valid;
  logic        [DATA_WIDTH-1:0]   r_mag;
  logic signed [DATA_WIDTH-1:0]   r_angle;

  logic signed [INT_WIDTH-1:0]    w_x_ext, w_y_ext;
  logic signed [INT_WIDTH-1:0]    w_atan;
  logic signed [INT_WIDTH-1:0]    w_x_next, w_y_next, w_z_next;
  logic signed [INT_WIDTH:0]      w_mag_sum, w_ang_sum, w_mag_q, w_ang_q;
  logic        [DATA_WIDTH-1:0]   w_mag_sat;
  logic signed [DATA_WIDTH-1:0]   w_ang_sat;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.mag_out   = r_mag;
  assign bus.angle_out = r_angle;

  // Q1.7 input -> Q3.11 internal: sign-extend and append fraction zeros
  assign w_x_ext = {{(INT_WIDTH-DATA_WIDTH-IN_SHIFT){bus.x_in[DATA_WIDTH-1]}}, bus.x_in, {IN_SHIFT{1'b0}}};
  assign w_y_ext = {{(INT_WIDTH-DATA_WIDTH-IN_SHIFT){bus.y_in[DATA_WIDTH-1]}}, bus.y_in, {IN_SHIFT{1'b0}}};
  assign w_atan  = INT_WIDTH'(c_atan_lut[r_iter]);

  cordic_vec_iter #(
    .WIDTH     (INT_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_iter (
    .x      (r_x),
    .y      (r_y),
    .z      (r_z),
    .i      (r_iter),
    .atan   (w_atan),
    .x_next (w_x_next),
    .y_next (w_y_next),
    .z_next (w_z_next)
  );

`ifdef GAIN_COMP_EN
  logic signed [INT_WIDTH-1:0] w_x_scaled;

  // x * K as a sum of arithmetic shifts
  always_comb begin
    w_x_scaled = '0;
    for (int k = 0; k < c_k_terms; k++) begin
      if (c_k_sub[k]) w_x_scaled = w_x_scaled - (r_x >>> c_k_shift[k]);
      else            w_x_scaled = w_x_scaled + (r_x >>> c_k_shift[k]);
    end
  end
`endif

  // round-half-up to output precision
  assign w_mag_sum = $signed({r_x[INT_WIDTH-1], r_x}) + c_mag_half;
  assign w_ang_sum = $signed({r_z[INT_WIDTH-1], r_z}) + c_ang_half;
  assign w_mag_q   = w_mag_sum >>> MAG_SHIFT;
  assign w_ang_q   = w_ang_sum >>> ANG_SHIFT;

  // clamp magnitude to [0, all-ones] and angle to the signed code range
  always_comb begin
    w_mag_sat = w_mag_q[DATA_WIDTH-1:0];
    if (w_mag_q < 0)              w_mag_sat = '0;
    else if (w_mag_q > c_mag_max) w_mag_sat = '1;
    w_ang_sat = w_ang_q[DATA_WIDTH-1:0];
    if (w_ang_q > c_ang_max)      w_ang_sat = c_ang_max[DATA_WIDTH-1:0];
    else if (w_ang_q < c_ang_min) w_ang_sat = c_ang_min[DATA_WIDTH-1:0];
  end

  // controller and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_angle     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_x        <= w_x_ext;
            r_y        <= w_y_ext;
            r_z        <= '0;
            r_zero     <= (bus.x_in == '0) && (bus.y_in == '0);
            r_in_ready <= 1'b0;
            r_state    <= S_PREROT;
          end
        end
        S_PREROT: begin
          // fold left half-plane into the right so iterations converge
          if (r_x[INT_WIDTH-1] && !r_y[INT_WIDTH-1]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= INT_WIDTH'(c_pi_2);
          end else if (r_x[INT_WIDTH-1]) begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -INT_WIDTH'(c_pi_2);
          end
          r_iter  <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          r_z <= w_z_next;
          if (r_iter == c_last_iter) begin
`ifdef GAIN_COMP_EN
            r_state <= S_SCALE;
`else
            r_state <= S_ROUND;
`endif
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
`ifdef GAIN_COMP_EN
        S_SCALE: begin
          r_x     <= w_x_scaled;
          r_state <= S_ROUND;
        end
`endif
        S_ROUND: begin
          // a zero vector has no angle; suppress the accumulated LUT residue
          r_mag       <= r_zero ? '0 : w_mag_sat;
          r_angle     <= r_zero ? '0 : w_ang_sat;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
// ============================================================================
//  Module      : tb_cordic_vectoring
//  Description : Directed self-checking bench for cordic_vectoring with
//                hand-computed magnitude/angle/latency expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_vectoring;

`ifdef GAIN_COMP_EN
  localparam int E_LAT      = 15;
  localparam int E_MAG_127  = 127;   // |(127,0)|
  localparam int E_MAG_128  = 128;   // |(-128,0)|, |(0,-128)|
  localparam int E_MAG_9090 = 127;   // 90*sqrt(2)
  localparam int E_MAG_DIAG = 181;   // 128*sqrt(2)
`else
  localparam int E_LAT      = 14;
  localparam int E_MAG_127  = 209;   // 127*1.6468
  localparam int E_MAG_128  = 211;   // 128*1.6468
  localparam int E_MAG_9090 = 210;   // 127.28*1.6468
  localparam int E_MAG_DIAG = 255;   // 298 saturates
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cordic_vectoring_if #(.DATA_WIDTH(8)) bus ();

  cordic_vectoring #(
    .DATA_WIDTH (8),
    .INT_WIDTH  (14),
    .ITER_COUNT (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // present one input and return at #1 after its handshake edge
  task automatic send(input int xv, input int yv);
    int n;
    @(negedge clk);
    bus.x_in     = 8'(xv);
    bus.y_in     = 8'(yv);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_val("in_ready_wait", n, 0, 63);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // count edges from the handshake until out_valid rises
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input int xv, input int yv,
                         input int e_mag, input int e_ang, input int tol);
    int lat;
    send(xv, yv);
    wait_out(lat);
    check_val({tag, "_lat"}, lat, E_LAT, 0);
    check_val({tag, "_mag"}, int'(bus.mag_out), e_mag, tol);
    check_val({tag, "_ang"}, int'($signed(bus.angle_out)), e_ang, tol);
    consume();
    check_val({tag, "_vld_clr"}, int'(bus.out_valid), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int m0, a0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready",  int'(bus.in_ready), 1, 0);
    check_val("rst_out_valid", int'(bus.out_valid), 0, 0);
    check_val("rst_mag",       int'(bus.mag_out), 0, 0);
    check_val("rst_ang",       int'($signed(bus.angle_out)), 0, 0);
    rst = 1'b0;

    run_vec("x127",     127,    0, E_MAG_127,    0, 1);
    run_vec("y127",       0,  127, E_MAG_127,   50, 1);
    run_vec("yneg128",    0, -128, E_MAG_128,  -50, 1);
    run_vec("xneg128", -128,    0, E_MAG_128,  101, 1);
    run_vec("diag90",    90,   90, E_MAG_9090,  25, 1);
    run_vec("diagneg", -128, -128, E_MAG_DIAG, -75, 1);
    run_vec("zero",       0,    0, 0,            0, 0);

    // stall the output while a second input waits
    send(127, 0);
    wait_out(lat);
    check_val("stall_lat", lat, E_LAT, 0);
    m0 = int'(bus.mag_out);
    a0 = int'($signed(bus.angle_out));
    check_val("stall_mag0", m0, E_MAG_127, 1);
    bus.x_in     = 8'sd0;
    bus.y_in     = 8'sd127;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_val("stall_vld",  int'(bus.out_valid), 1, 0);
      check_val("stall_rdy",  int'(bus.in_ready), 0, 0);
      check_val("stall_mag",  int'(bus.mag_out), m0, 0);
      check_val("stall_ang",  int'($signed(bus.angle_out)), a0, 0);
    end
    consume();
    check_val("b2b_idle_rdy", int'(bus.in_ready), 1, 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check_val("b2b_taken", int'(bus.in_ready), 0, 0);
    wait_out(lat);
    check_val("b2b_lat", lat, E_LAT, 0);
    check_val("b2b_ang", int'($signed(bus.angle_out)), 50, 1);
    consume();

    // reset in the middle of the iterations
    send(127, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_vld", int'(bus.out_valid), 0, 0);
    check_val("mid_rst_rdy", int'(bus.in_ready), 1, 0);
    check_val("mid_rst_mag", int'(bus.mag_out), 0, 0);
    check_val("mid_rst_ang", int'($signed(bus.angle_out)), 0, 0);
    rst = 1'b0;

    run_vec("post_rst", 127, 0, E_MAG_127, 0, 1);
    run_vec("zero2",      0, 0, 0,         0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
